// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } t_fetch_state;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps at most one memory request
// outstanding, and presents the fetched instruction to the decode register.
// Redirects from execute take priority over stalls; a response made stale by a
// redirect is swallowed in DROP so it never reaches decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_fetch,
    input  logic                   i_redirect,
    input  logic [DATA_WIDTH-1:0]  i_redirect_target,
    output logic                   o_imem_req_valid,
    input  logic                   i_imem_req_ready,
    output logic [DATA_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0]  o_pc,
    output logic [DATA_WIDTH-1:0]  o_pc_plus4,
    output logic                   o_fetch_valid,
    output logic                   o_stall_req
);

    t_fetch_state           state;
    logic [DATA_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] buffer;
    logic [DATA_WIDTH-1:0]  pc_next_seq;
    logic                   in_hold;
    logic                   in_req;

    assign pc_next_seq = pc + DATA_WIDTH'(PC_STEP);
    assign in_hold     = (state == HOLD);
    assign in_req      = (state == REQ);

    // Fetch sequencer: advances the PC, tracks the outstanding request and buffers the response.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end

                REQ: begin
                    if (i_redirect) begin
                        pc <= i_redirect_target;
                        if (i_imem_req_ready) begin
                            state <= DROP;
                        end
                    end else if (i_imem_req_ready) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (i_redirect) begin
                        pc <= i_redirect_target;
                        state <= i_imem_rsp_valid ? REQ : DROP;
                    end else if (i_imem_rsp_valid) begin
                        buffer <= i_imem_rsp_data;
                        state  <= HOLD;
                    end
                end

                DROP: begin
                    // A response seen here is always the stale one, even when a
                    // further redirect lands in the same cycle, so it clears the
                    // outstanding request and lets the newest PC be fetched.
                    if (i_redirect) begin
                        pc <= i_redirect_target;
                    end
                    if (i_imem_rsp_valid) begin
                        state <= REQ;
                    end
                end

                HOLD: begin
                    if (i_redirect) begin
                        pc    <= i_redirect_target;
                        state <= REQ;
                    end else if (!i_stall_fetch) begin
                        pc    <= pc_next_seq;
                        state <= REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state/pc/buffer only; outside HOLD they look like a flushed decode register.
    assign o_imem_req_valid = in_req;
    assign o_imem_addr      = in_req  ? pc          : '0;
    assign o_fetch_valid    = in_hold;
    assign o_stall_req      = ~in_hold;
    assign o_instr          = in_hold ? buffer      : '0;
    assign o_pc             = in_hold ? pc          : '0;
    assign o_pc_plus4       = in_hold ? pc_next_seq : '0;

endmodule
